xge_rx_pktgen: RTL and testbench

XGE_RX_PKTGEN -- requirements
Module: xge_rx_pktgen

---
 rtl/xge_rx_pktgen.sv | 155 +++++++++++++++
 tb/tb_xge_rx_pktgen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/xge_rx_pktgen.sv
// Synthetic 10G MAC rx frame source: numbered payload, periodic bad frames, IFG.
// Outputs registered (word 0 one cycle after the IDLE cycle); no backpressure.
module xge_rx_pktgen (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [13:0] pkt_len,
  input  logic [7:0]  ifg,
  input  logic [7:0]  bad_every,
  output logic [63:0] rx_data,
  output logic [7:0]  rx_data_valid,
  output logic        rx_good_frame,
  output logic        rx_bad_frame,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, STATUS, GAP} state_t;

  state_t      state, state_nxt;
  logic [10:0] last_q, last_nxt;
  logic [10:0] widx_q, widx_nxt;
  logic [7:0]  tail_q, tail_nxt;
  logic [7:0]  ifg_q, ifg_nxt;
  logic [7:0]  gap_q, gap_nxt;
  logic        bad_q, bad_nxt;
  logic [7:0]  mod_q, mod_nxt;
  logic [15:0] seq_q, seq_nxt;

  logic [63:0] data_nxt;
  logic [7:0]  valid_nxt;
  logic        good_pulse_nxt, bad_pulse_nxt;
  logic [31:0] good_cnt_nxt, bad_cnt_nxt;

  logic [13:0] len_eff, len_m1;
  logic [10:0] start_last;
  logic [7:0]  start_tail, vmask;
  logic        start_bad;

  // Lanes outside vmask are forced to zero.
  function automatic logic [63:0] gen_word(input logic [10:0] w, input logic [7:0] s,
                                           input logic [7:0] vm);
    logic [63:0] d;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      if (vm[j]) d[8*j +: 8] = {w[4:0], 3'(j)} ^ s;
    end
    return d;
  endfunction

  always_comb begin
    len_eff    = (pkt_len < 14'd8) ? 14'd8 : pkt_len;
    len_m1     = len_eff - 14'd1;
    start_last = len_m1[13:3];
    start_tail = (len_eff[2:0] == 3'd0) ? 8'hFF : ((8'h01 << len_eff[2:0]) - 8'h01);
    start_bad  = (bad_every != 8'd0) && (mod_q == bad_every - 8'd1);
  end

  always_comb begin
    state_nxt      = state;
    last_nxt       = last_q;
    widx_nxt       = widx_q;
    tail_nxt       = tail_q;
    ifg_nxt        = ifg_q;
    gap_nxt        = gap_q;
    bad_nxt        = bad_q;
    mod_nxt        = mod_q;
    seq_nxt        = seq_q;
    data_nxt       = '0;
    valid_nxt      = 8'h00;
    good_pulse_nxt = 1'b0;
    bad_pulse_nxt  = 1'b0;
    good_cnt_nxt   = good_cnt;
    bad_cnt_nxt    = bad_cnt;
    vmask          = 8'hFF;

    case (state)
      IDLE: begin
        if (enable) begin
          last_nxt  = start_last;
          tail_nxt  = start_tail;
          ifg_nxt   = ifg;
          bad_nxt   = start_bad;
          if (bad_every != 8'd0) mod_nxt = start_bad ? 8'd0 : mod_q + 8'd1;
          widx_nxt  = '0;
          vmask     = (start_last == 11'd0) ? start_tail : 8'hFF;
          data_nxt  = gen_word(11'd0, seq_q[7:0], vmask);
          valid_nxt = vmask;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (widx_q == last_q) begin
          good_pulse_nxt = !bad_q;
          bad_pulse_nxt  = bad_q;
          if (bad_q) bad_cnt_nxt = bad_cnt + 32'd1;
          else       good_cnt_nxt = good_cnt + 32'd1;
          seq_nxt   = seq_q + 16'd1;
          state_nxt = STATUS;
        end else begin
          widx_nxt  = widx_q + 11'd1;
          vmask     = (widx_nxt == last_q) ? tail_q : 8'hFF;
          data_nxt  = gen_word(widx_nxt, seq_q[7:0], vmask);
          valid_nxt = vmask;
        end
      end
      STATUS: begin
        gap_nxt   = ifg_q;
        state_nxt = (ifg_q == 8'd0) ? IDLE : GAP;
      end
      GAP: begin
        gap_nxt = gap_q - 8'd1;
        if (gap_q == 8'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_q        <= '0;
      widx_q        <= '0;
      tail_q        <= 8'h00;
      ifg_q         <= 8'h00;
      gap_q         <= 8'h00;
      bad_q         <= 1'b0;
      mod_q         <= 8'h00;
      seq_q         <= 16'h0000;
      rx_data       <= '0;
      rx_data_valid <= 8'h00;
      rx_good_frame <= 1'b0;
      rx_bad_frame  <= 1'b0;
      good_cnt      <= 32'd0;
      bad_cnt       <= 32'd0;
    end else begin
      state         <= state_nxt;
      last_q        <= last_nxt;
      widx_q        <= widx_nxt;
      tail_q        <= tail_nxt;
      ifg_q         <= ifg_nxt;
      gap_q         <= gap_nxt;
      bad_q         <= bad_nxt;
      mod_q         <= mod_nxt;
      seq_q         <= seq_nxt;
      rx_data       <= data_nxt;
      rx_data_valid <= valid_nxt;
      rx_good_frame <= good_pulse_nxt;
      rx_bad_frame  <= bad_pulse_nxt;
      good_cnt      <= good_cnt_nxt;
      bad_cnt       <= bad_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_xge_rx_pktgen.sv
// Directed bench for xge_rx_pktgen: frame content, clamping, bad cadence, IFG,
// enable drop and mid-frame reset.
module tb_xge_rx_pktgen;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [13:0] pkt_len;
  logic [7:0]  ifg, bad_every;
  logic [63:0] rx_data;
  logic [7:0]  rx_data_valid;
  logic        rx_good_frame, rx_bad_frame;
  logic [31:0] good_cnt, bad_cnt;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  xge_rx_pktgen dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .pkt_len       (pkt_len),
    .ifg           (ifg),
    .bad_every     (bad_every),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_good_frame (rx_good_frame),
    .rx_bad_frame  (rx_bad_frame),
    .good_cnt      (good_cnt),
    .bad_cnt       (bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Byte i of a frame exists iff i < L; its value is i ^ seq.
  function automatic logic [63:0] exp_word(input int len, input int w, input int seq);
    logic [63:0] r;
    int L;
    L = (len < 8) ? 8 : len;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (8*w + j < L) r[8*j +: 8] = 8'((8*w + j) ^ seq);
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_valid(input int len, input int w);
    logic [63:0] r;
    int L;
    L = (len < 8) ? 8 : len;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (8*w + j < L) r[j] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input int len, input int w, input int seq);
    chk($sformatf("%s.w%0d.dat", tag, w), rx_data, exp_word(len, w, seq));
    chk($sformatf("%s.w%0d.vld", tag, w), {56'd0, rx_data_valid}, exp_valid(len, w));
    chk($sformatf("%s.w%0d.st", tag, w), {62'd0, rx_good_frame, rx_bad_frame}, 64'd0);
  endtask

  // Expects word 0 on the next edge; optionally changes pkt_len after word 0
  // and drops enable after word drop_w.
  task automatic frame(input string tag, input int len, input int seq, input bit bad,
                       input int new_len, input int drop_w);
    int L, nw;
    L  = (len < 8) ? 8 : len;
    nw = (L + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      tick();
      chk_word(tag, len, w, seq);
      if (w == 0 && new_len >= 0) pkt_len = 14'(new_len);
      if (w == drop_w) enable = 1'b0;
    end
    tick();
    chk({tag, ".status"}, {62'd0, rx_good_frame, rx_bad_frame}, {62'd0, !bad, bad});
    chk({tag, ".st_dat"}, rx_data | {56'd0, rx_data_valid}, 64'd0);
  endtask

  task automatic idle_chk(input string tag);
    tick();
    chk({tag, ".idle"}, rx_data | {54'd0, rx_data_valid, rx_good_frame, rx_bad_frame}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; pkt_len = 14'd64; ifg = 8'd0; bad_every = 8'd0;
    tick(); tick(); tick();
    chk("rst.dat", rx_data, 64'd0);
    chk("rst.vld", {56'd0, rx_data_valid}, 64'd0);
    chk("rst.st", {62'd0, rx_good_frame, rx_bad_frame}, 64'd0);
    chk("rst.cnt", {good_cnt, bad_cnt}, 64'd0);

    // 64-byte frames, enable held through reset, back-to-back with ifg=0
    enable = 1'b1;
    do_reset();
    chk("t2.pre_idle", {56'd0, rx_data_valid}, 64'd0);
    tick();
    chk("t2.word0", rx_data, 64'h0706050403020100);
    chk("t2.vld0", {56'd0, rx_data_valid}, 64'hFF);
    for (int w = 1; w < 8; w++) begin
      tick();
      chk_word("t2.f0", 64, w, 0);
    end
    tick();
    chk("t2.f0.status", {62'd0, rx_good_frame, rx_bad_frame}, 64'd2);
    idle_chk("t2.f0");
    frame("t2.f1", 64, 1, 1'b0, -1, -1);
    idle_chk("t2.f1");
    frame("t2.f2", 64, 2, 1'b0, -1, -1);
    chk("t2.good_cnt", {32'd0, good_cnt}, 64'd3);
    chk("t2.bad_cnt", {32'd0, bad_cnt}, 64'd0);

    // partial last word, mid-frame length change, clamping of short lengths
    enable = 1'b1; pkt_len = 14'd61;
    do_reset();
    frame("t3.f0", 61, 0, 1'b0, 16, -1);
    idle_chk("t3.f0");
    tick();
    chk("t3.f1.word0", rx_data, 64'h0607040502030001);
    pkt_len = 14'd3;
    tick();
    chk_word("t3.f1", 16, 1, 1);
    tick();
    chk("t3.f1.status", {62'd0, rx_good_frame, rx_bad_frame}, 64'd2);
    idle_chk("t3.f1");
    tick();
    chk("t3.f2.word0", rx_data, 64'h0504070601000302);
    chk("t3.f2.vld0", {56'd0, rx_data_valid}, 64'hFF);
    tick();
    chk("t3.f2.status", {62'd0, rx_good_frame, rx_bad_frame}, 64'd2);

    // every 3rd frame bad; hand-checked final word of the 61-byte frame
    chk("t3.w7_hand", exp_word(61, 7, 0), 64'h0000003C3B3A3938);
    enable = 1'b1; pkt_len = 14'd8; bad_every = 8'd3;
    do_reset();
    frame("t4.f0", 8, 0, 1'b0, -1, -1); idle_chk("t4.f0");
    frame("t4.f1", 8, 1, 1'b0, -1, -1); idle_chk("t4.f1");
    frame("t4.f2", 8, 2, 1'b1, -1, -1); idle_chk("t4.f2");
    frame("t4.f3", 8, 3, 1'b0, -1, -1); idle_chk("t4.f3");
    frame("t4.f4", 8, 4, 1'b0, -1, -1); idle_chk("t4.f4");
    frame("t4.f5", 8, 5, 1'b1, -1, -1); idle_chk("t4.f5");
    frame("t4.f6", 8, 6, 1'b0, -1, -1);
    chk("t4.good_cnt", {32'd0, good_cnt}, 64'd5);
    chk("t4.bad_cnt", {32'd0, bad_cnt}, 64'd2);

    // ifg=5: STATUS, 5 GAP, 1 IDLE, then DATA
    enable = 1'b1; pkt_len = 14'd8; bad_every = 8'd0; ifg = 8'd5;
    do_reset();
    frame("t5.f0", 8, 0, 1'b0, -1, -1);
    for (int i = 0; i < 6; i++) idle_chk($sformatf("t5.gap%0d", i));
    frame("t5.f1", 8, 1, 1'b0, -1, -1);

    // enable dropped during word 1: frame completes, nothing follows
    enable = 1'b1; pkt_len = 14'd64; ifg = 8'd0;
    do_reset();
    frame("t6.f0", 64, 0, 1'b0, -1, 1);
    for (int i = 0; i < 10; i++) idle_chk($sformatf("t6.after%0d", i));
    chk("t6.good_cnt", {32'd0, good_cnt}, 64'd1);

    // reset in word 4 aborts silently; next frame starts from seq 0
    enable = 1'b1;
    do_reset();
    for (int w = 0; w < 5; w++) begin
      tick();
      chk_word("t7.f0", 64, w, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7.abort.out", rx_data | {54'd0, rx_data_valid, rx_good_frame, rx_bad_frame}, 64'd0);
    chk("t7.abort.cnt", {good_cnt, bad_cnt}, 64'd0);
    frame("t7.f1", 64, 0, 1'b0, -1, -1);
    chk("t7.good_cnt", {32'd0, good_cnt}, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
